// File: rtl/pipe_vec_elastic_if.sv
// Handshake bundle for pipe_vec_elastic: upstream valid/ready/data, flush,
// downstream valid/ready/data and the occupancy count.
interface pipe_vec_elastic_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
);
   localparam int CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_data;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_data;
   logic [CW-1:0]    o_count;

   modport master (
      output i_valid, i_data, i_flush, i_ready,
      input  o_ready, o_valid, o_data, o_count
   );

   modport slave (
      input  i_valid, i_data, i_flush, i_ready,
      output o_ready, o_valid, o_data, o_count
   );
endinterface

// File: rtl/pipe_vec_elastic.sv
// Elastic WIDTH-bit pipeline of DEPTH valid/ready register stages with
// bubble collapsing, synchronous flush and a registered occupancy count.
module pipe_vec_elastic #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 2,
   parameter bit RESET_DATA = 1'b0
) (
   input logic               clk,
   input logic               reset,
   pipe_vec_elastic_if.slave bus
);
   localparam int CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

   generate
      if (DEPTH == 0) begin : g_pass
         assign bus.o_valid = bus.i_valid;
         assign bus.o_data  = bus.i_data;
         assign bus.o_ready = bus.i_ready;
         assign bus.o_count = '0;
      end else begin : g_pipe
         logic [DEPTH-1:0]            v_reg;
         logic [DEPTH-1:0]            v_next;
         logic [DEPTH-1:0]            adv;
         logic [DEPTH:0]              v_chain;
         logic [DEPTH:0][WIDTH-1:0]   d_chain;
         logic [CW-1:0]               count_reg;
         logic [CW-1:0]               count_next;

         // Element 0 of each chain is the upstream input; element k+1 is stage k.
         assign v_chain    = {v_reg, bus.i_valid};
         assign d_chain[0] = bus.i_data;

         // A stage may load whenever it is empty or everything below it moves.
         always_comb begin
            adv            = '0;
            adv[DEPTH-1]   = !v_reg[DEPTH-1] || bus.i_ready;
            for (int k = DEPTH - 2; k >= 0; k--) begin
               adv[k] = !v_reg[k] || adv[k+1];
            end
         end

         always_comb begin
            v_next     = v_reg;
            count_next = '0;
            for (int k = 0; k < DEPTH; k++) begin
               if (adv[k]) begin
                  v_next[k] = v_chain[k];
               end
            end
            if (bus.i_flush) begin
               v_next = '0;
            end
            for (int k = 0; k < DEPTH; k++) begin
               count_next = count_next + CW'(v_next[k]);
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               v_reg     <= '0;
               count_reg <= '0;
            end else begin
               v_reg     <= v_next;
               count_reg <= count_next;
            end
         end

         for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] d_reg;

            // Payload follows the advance enable only; a flush leaves it alone.
            if (RESET_DATA) begin : g_rst
               always_ff @(posedge clk or posedge reset) begin
                  if (reset) begin
                     d_reg <= '0;
                  end else if (adv[gi]) begin
                     d_reg <= d_chain[gi];
                  end
               end
            end else begin : g_norst
               always_ff @(posedge clk) begin
                  if (adv[gi]) begin
                     d_reg <= d_chain[gi];
                  end
               end
            end

            assign d_chain[gi+1] = d_reg;
         end

         assign bus.o_valid = v_reg[DEPTH-1];
         assign bus.o_data  = d_chain[DEPTH];
         assign bus.o_ready = adv[0] && !bus.i_flush;
         assign bus.o_count = count_reg;
      end
   endgenerate
endmodule

// File: tb/tb_pipe_vec_elastic.sv
// Directed bench for pipe_vec_elastic at DEPTH 3, 4, 0 and 1 with
// hand-computed expectations for streaming, stall, bubble, flush and reset.
module tb_pipe_vec_elastic;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pipe_vec_elastic_if #(.WIDTH(8), .DEPTH(3)) bus3 ();
   pipe_vec_elastic_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
   pipe_vec_elastic_if #(.WIDTH(8), .DEPTH(0)) bus0 ();
   pipe_vec_elastic_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

   pipe_vec_elastic #(.WIDTH(8), .DEPTH(3), .RESET_DATA(1'b1)) u_d3 (.clk(clk), .reset(reset), .bus(bus3));
   pipe_vec_elastic #(.WIDTH(8), .DEPTH(4), .RESET_DATA(1'b0)) u_d4 (.clk(clk), .reset(reset), .bus(bus4));
   pipe_vec_elastic #(.WIDTH(8), .DEPTH(0), .RESET_DATA(1'b0)) u_d0 (.clk(clk), .reset(reset), .bus(bus0));
   pipe_vec_elastic #(.WIDTH(8), .DEPTH(1), .RESET_DATA(1'b0)) u_d1 (.clk(clk), .reset(reset), .bus(bus1));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Leaves the bench 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      int out_idx;
      bit acc;

      reset = 1'b1;
      bus3.i_valid = 0; bus3.i_data = '0; bus3.i_flush = 0; bus3.i_ready = 0;
      bus4.i_valid = 0; bus4.i_data = '0; bus4.i_flush = 0; bus4.i_ready = 0;
      bus0.i_valid = 0; bus0.i_data = '0; bus0.i_flush = 0; bus0.i_ready = 0;
      bus1.i_valid = 0; bus1.i_data = '0; bus1.i_flush = 0; bus1.i_ready = 0;
      #1;
      check_val("rst d3 o_valid", 32'(bus3.o_valid), 0);
      check_val("rst d3 o_count", 32'(bus3.o_count), 0);
      check_val("rst d3 o_ready", 32'(bus3.o_ready), 1);
      check_val("rst d4 o_count", 32'(bus4.o_count), 0);
      check_val("rst d1 o_valid", 32'(bus1.o_valid), 0);
      tick();
      tick();
      reset = 1'b0;

      // Unstalled stream 0x01..0x0A through DEPTH=3
      bus3.i_ready = 1;
      for (int i = 0; i < 14; i++) begin
         bus3.i_valid = (i < 10);
         bus3.i_data  = 8'(i + 1);
         #1;
         check_val($sformatf("stream count c%0d", i), 32'(bus3.o_count),
                   (i <= 3) ? i : ((i <= 10) ? 3 : 13 - i));
         check_val($sformatf("stream o_valid c%0d", i), 32'(bus3.o_valid),
                   (i >= 3 && i <= 12) ? 1 : 0);
         if (i >= 3 && i <= 12)
            check_val($sformatf("stream o_data c%0d", i), 32'(bus3.o_data), i - 2);
         tick();
      end
      bus3.i_valid = 0;

      // Backpressure: 5 values against a stalled DEPTH=3 pipe
      bus3.i_ready = 0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         bus3.i_valid = (idx < 5);
         bus3.i_data  = 8'(8'h11 + idx);
         #1;
         acc = bus3.i_valid && bus3.o_ready;
         tick();
         if (acc) idx++;
      end
      bus3.i_valid = 1;
      bus3.i_data  = 8'(8'h11 + idx);
      #1;
      check_val("stall accepted", idx, 3);
      check_val("stall o_ready", 32'(bus3.o_ready), 0);
      check_val("stall o_count", 32'(bus3.o_count), 3);
      check_val("stall o_valid", 32'(bus3.o_valid), 1);
      check_val("stall o_data", 32'(bus3.o_data), 32'h11);
      bus3.i_ready = 1;
      out_idx = 0;
      for (int c = 0; c < 20 && out_idx < 5; c++) begin
         bus3.i_valid = (idx < 5);
         bus3.i_data  = 8'(8'h11 + idx);
         #1;
         acc = bus3.i_valid && bus3.o_ready;
         if (bus3.o_valid) begin
            check_val($sformatf("drain o_data #%0d", out_idx), 32'(bus3.o_data), 32'h11 + out_idx);
            out_idx++;
         end
         tick();
         if (acc) idx++;
      end
      bus3.i_valid = 0;
      #1;
      check_val("drain delivered", out_idx, 5);
      check_val("drain o_valid", 32'(bus3.o_valid), 0);
      check_val("drain o_count", 32'(bus3.o_count), 0);

      // Bubble collapse in DEPTH=4: A, two idles, B, all with i_ready=0
      bus4.i_ready = 0;
      for (int c = 0; c < 8; c++) begin
         bus4.i_valid = (c == 0 || c == 3);
         bus4.i_data  = (c == 0) ? 8'hA1 : 8'hB2;
         tick();
      end
      bus4.i_valid = 0;
      #1;
      check_val("bubble o_count", 32'(bus4.o_count), 2);
      check_val("bubble o_ready", 32'(bus4.o_ready), 1);
      check_val("bubble head A", 32'(bus4.o_data), 32'hA1);
      bus4.i_ready = 1;
      tick();
      check_val("bubble next B", 32'(bus4.o_data), 32'hB2);
      check_val("bubble B valid", 32'(bus4.o_valid), 1);
      tick();
      check_val("bubble empty", 32'(bus4.o_valid), 0);

      // Flush of a full DEPTH=3 pipe while the head transfers
      bus3.i_ready = 0;
      for (int c = 0; c < 3; c++) begin
         bus3.i_valid = 1;
         bus3.i_data  = 8'(8'h31 + c);
         tick();
      end
      #1;
      check_val("flush pre count", 32'(bus3.o_count), 3);
      bus3.i_flush = 1; bus3.i_valid = 1; bus3.i_data = 8'hFF; bus3.i_ready = 1;
      #1;
      check_val("flush o_ready", 32'(bus3.o_ready), 0);
      check_val("flush head valid", 32'(bus3.o_valid), 1);
      check_val("flush head data", 32'(bus3.o_data), 32'h31);
      tick();
      bus3.i_flush = 0; bus3.i_valid = 0;
      #1;
      check_val("flush post o_valid", 32'(bus3.o_valid), 0);
      check_val("flush post o_count", 32'(bus3.o_count), 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_val($sformatf("flush dropped c%0d", c), 32'(bus3.o_valid), 0);
      end

      // Asynchronous reset with two entries in flight
      bus3.i_ready = 0;
      bus3.i_valid = 1; bus3.i_data = 8'h41;
      tick();
      bus3.i_data = 8'h42;
      tick();
      bus3.i_valid = 0;
      tick();
      check_val("rst mid pre count", 32'(bus3.o_count), 2);
      check_val("rst mid pre data", 32'(bus3.o_data), 32'h41);
      #2;
      reset = 1'b1;
      #1;
      check_val("rst mid o_valid", 32'(bus3.o_valid), 0);
      check_val("rst mid o_count", 32'(bus3.o_count), 0);
      check_val("rst mid o_data", 32'(bus3.o_data), 0);
      check_val("rst mid o_ready", 32'(bus3.o_ready), 1);
      #2;
      reset = 1'b0;
      bus3.i_valid = 1; bus3.i_data = 8'h55;
      tick();
      bus3.i_valid = 0;
      check_val("rst lat e1", 32'(bus3.o_valid), 0);
      tick();
      check_val("rst lat e2", 32'(bus3.o_valid), 0);
      tick();
      check_val("rst lat e3 valid", 32'(bus3.o_valid), 1);
      check_val("rst lat e3 data", 32'(bus3.o_data), 32'h55);
      bus3.i_ready = 1;
      tick();

      // DEPTH=0 passthrough, flush ignored
      bus0.i_valid = 1; bus0.i_data = 8'h5A; bus0.i_ready = 0; bus0.i_flush = 1;
      #1;
      check_val("pass o_valid", 32'(bus0.o_valid), 1);
      check_val("pass o_data", 32'(bus0.o_data), 32'h5A);
      check_val("pass o_ready lo", 32'(bus0.o_ready), 0);
      bus0.i_ready = 1;
      #1;
      check_val("pass o_ready hi", 32'(bus0.o_ready), 1);
      check_val("pass o_count", 32'(bus0.o_count), 0);
      bus0.i_valid = 0; bus0.i_flush = 0;
      #1;
      check_val("pass o_valid lo", 32'(bus0.o_valid), 0);

      // DEPTH=1 with i_ready toggling every cycle
      idx = 0;
      out_idx = 0;
      for (int c = 0; c < 40 && out_idx < 8; c++) begin
         bus1.i_ready = c[0];
         bus1.i_valid = (idx < 8);
         bus1.i_data  = 8'(8'h61 + idx);
         #1;
         acc = bus1.i_valid && bus1.o_ready;
         if (bus1.o_valid && bus1.i_ready) begin
            check_val($sformatf("d1 o_data #%0d", out_idx), 32'(bus1.o_data), 32'h61 + out_idx);
            out_idx++;
         end
         tick();
         if (acc) idx++;
      end
      bus1.i_valid = 0;
      check_val("d1 delivered", out_idx, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
